// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer sitting directly behind the UART receiver.
//   Single-cycle byte strobes from the receiver are captured into a circular
//   FIFO and handed to the consumer through a first-word-fall-through
//   valid/ready interface. RTS is driven with hysteresis so the remote
//   transmitter pauses before the buffer fills, and a sticky flag records
//   any byte dropped because the FIFO was full.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   wr_data[7:0]   in   received byte
//   wr_valid       in   one-cycle strobe, wr_data is present
//   rd_data[7:0]   out  byte at FIFO head, meaningful while rd_valid=1
//   rd_valid       out  FIFO non-empty
//   rd_ready       in   consumer takes the head byte this cycle
//   rts            out  active-low request-to-send (1 = stop sending)
//   count          out  occupancy 0..DEPTH
//   overflow       out  sticky, a byte was dropped while full
//   clear_overflow in   one-cycle pulse clearing overflow
module uart_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int RTS_HIGH_WATER = 12,
  parameter int RTS_LOW_WATER  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rts,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam logic [ADDR_W:0] ONE_C  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] HIGH_C = RTS_HIGH_WATER[ADDR_W:0];
  localparam logic [ADDR_W:0] LOW_C  = RTS_LOW_WATER[ADDR_W:0];

  logic [7:0]      mem_r [DEPTH];
  logic [ADDR_W:0] wr_ptr_r;
  logic [ADDR_W:0] rd_ptr_r;
  logic [ADDR_W:0] count_r;
  logic            overflow_r;
  logic            rts_r;

  logic            empty_s;
  logic            full_s;
  logic            rd_en_s;
  logic            wr_en_s;
  logic            drop_s;

  // The extra pointer MSB is a wrap bit: equal pointers mean empty, pointers
  // differing only in the wrap bit mean full.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                   (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);

  // A read while full frees the slot the write needs, so both proceed.
  assign rd_en_s = !empty_s && rd_ready;
  assign wr_en_s = wr_valid && (!full_s || rd_en_s);
  assign drop_s  = wr_valid && full_s && !rd_en_s;

  // Head byte falls through straight from storage; no path from wr_valid.
  assign rd_data  = mem_r[rd_ptr_r[ADDR_W-1:0]];
  assign rd_valid = !empty_s;
  assign count    = count_r;
  assign overflow = overflow_r;
  assign rts      = rts_r;

  // Byte storage, intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Write and read pointers; the index wraps naturally modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {(ADDR_W+1){1'b0}};
      rd_ptr_r <= {(ADDR_W+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_C;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_C;
      end
    end
  end

  // Registered occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {(ADDR_W+1){1'b0}};
    end else begin
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow; a drop on the same edge as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clear_overflow) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // RTS hysteresis from the registered count; holds between the watermarks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rts_r <= 1'b0;
    end else if (!rts_r && (count_r >= HIGH_C)) begin
      rts_r <= 1'b1;
    end else if (rts_r && (count_r <= LOW_C)) begin
      rts_r <= 1'b0;
    end else begin
      rts_r <= rts_r;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       rts;
  logic [4:0] count;
  logic       overflow;
  logic       clear_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: model FIFO contents, bytes the model says leave, bytes the DUT hands over
  logic [7:0] exp_q[$];
  logic [7:0] exp_out_q[$];
  logic [7:0] act_q[$];
  logic       m_rts;
  logic       m_ovf;

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .RTS_HIGH_WATER(12), .RTS_LOW_WATER(4)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rts(rts),
    .count(count), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, update the model, step past the edge.
  task automatic step(input logic wv, input logic [7:0] wd, input logic rr, input logic co);
    bit rd_fire, wr_fire, drop;
    wr_valid = wv; wr_data = wd; rd_ready = rr; clear_overflow = co;
    if (rd_valid === 1'b1 && rr) act_q.push_back(rd_data);
    rd_fire = (exp_q.size() > 0) && rr;
    wr_fire = wv && ((exp_q.size() < DEPTH) || rd_fire);
    drop    = wv && (exp_q.size() == DEPTH) && !rd_fire;
    if (!m_rts && exp_q.size() >= 12) m_rts = 1'b1;
    else if (m_rts && exp_q.size() <= 4) m_rts = 1'b0;
    if (rd_fire) exp_out_q.push_back(exp_q.pop_front());
    if (wr_fire) exp_q.push_back(wd);
    if (drop) m_ovf = 1'b1;
    else if (co) m_ovf = 1'b0;
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_ready = 1'b0; clear_overflow = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete(); exp_out_q.delete(); act_q.delete();
    m_rts = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0; clear_overflow = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    n_checks++; if (rts !== 1'b0) begin n_fail++; $display("FAIL reset_rts got %b exp 0", rts); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [7:0] a;
    step(1'b1, 8'h41, 1'b0, 1'b0);
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_rd_valid got %b exp 1", rd_valid); end
    n_checks++; if (rd_data !== 8'h41) begin n_fail++; $display("FAIL single_rd_data got %h exp 41", rd_data); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", count); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty got %b exp 0", rd_valid); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL single_count0 got %0d exp 0", count); end
    n_checks++;
    if (act_q.size() != 1) begin n_fail++; $display("FAIL single_nreads got %0d exp 1", act_q.size()); end
    else begin
      a = act_q.pop_front();
      if (a !== 8'h41) begin n_fail++; $display("FAIL single_read got %h exp 41", a); end
    end
    act_q.delete(); exp_out_q.delete();
  endtask

  task automatic test_fill_overflow();
    logic [7:0] a, e;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count got %0d exp 16", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow got %b exp 0", overflow); end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_overflow got %b exp 1", overflow); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL drop_count got %0d exp 16", count); end
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL drain_count got %0d exp 0", count); end
    n_checks++; if (act_q.size() != exp_out_q.size()) begin n_fail++; $display("FAIL drain_nreads got %0d exp %0d", act_q.size(), exp_out_q.size()); end
    while (act_q.size() > 0 && exp_out_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_out_q.pop_front();
      n_checks++; if (a !== e || a === 8'hFF) begin n_fail++; $display("FAIL drain_data got %h exp %h", a, e); end
    end
    act_q.delete(); exp_out_q.delete();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clear_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_full_rw();
    logic [7:0] a, e, last;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fullrw_count got %0d exp 16", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullrw_overflow got %b exp 0", overflow); end
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    last = (act_q.size() > 0) ? act_q[act_q.size()-1] : 8'hxx;
    n_checks++; if (last !== 8'hAA) begin n_fail++; $display("FAIL fullrw_last got %h exp aa", last); end
    n_checks++; if (act_q.size() != exp_out_q.size()) begin n_fail++; $display("FAIL fullrw_nreads got %0d exp %0d", act_q.size(), exp_out_q.size()); end
    while (act_q.size() > 0 && exp_out_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_out_q.pop_front();
      n_checks++; if (a !== e) begin n_fail++; $display("FAIL fullrw_data got %h exp %h", a, e); end
    end
    act_q.delete(); exp_out_q.delete();
  endtask

  task automatic test_rts();
    logic [7:0] a, e;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      n_checks++; if (count !== 5'(i) || rts !== 1'b0) begin n_fail++; $display("FAIL rts_fill count %0d rts %b exp count %0d rts 0", count, rts, i); end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (rts !== 1'b1) begin n_fail++; $display("FAIL rts_high got %b exp 1", rts); end
    for (int c = 11; c >= 4; c--) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++; if (count !== 5'(c) || rts !== 1'b1) begin n_fail++; $display("FAIL rts_drain count %0d rts %b exp count %0d rts 1", count, rts, c); end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (rts !== 1'b0 || rts !== m_rts) begin n_fail++; $display("FAIL rts_low got %b exp 0", rts); end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (act_q.size() != exp_out_q.size()) begin n_fail++; $display("FAIL rts_nreads got %0d exp %0d", act_q.size(), exp_out_q.size()); end
    while (act_q.size() > 0 && exp_out_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_out_q.pop_front();
      n_checks++; if (a !== e) begin n_fail++; $display("FAIL rts_data got %h exp %h", a, e); end
    end
    act_q.delete(); exp_out_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, e;
    int max_count = 0;
    step(1'b1, 8'h80, 1'b0, 1'b0);
    for (int i = 1; i < 40; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      if (int'(count) > max_count) max_count = int'(count);
      n_checks++; if (count !== 5'(exp_q.size())) begin n_fail++; $display("FAIL b2b_count got %0d exp %0d", count, exp_q.size()); end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (max_count > 2) begin n_fail++; $display("FAIL b2b_max_count got %0d exp <=2", max_count); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL b2b_final_count got %0d exp 0", count); end
    n_checks++; if (act_q.size() != 40 || exp_out_q.size() != 40) begin n_fail++; $display("FAIL b2b_nreads got %0d exp 40", act_q.size()); end
    while (act_q.size() > 0 && exp_out_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_out_q.pop_front();
      n_checks++; if (a !== e) begin n_fail++; $display("FAIL b2b_data got %h exp %h", a, e); end
    end
    act_q.delete(); exp_out_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] a, e;
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (count !== 5'd7 || overflow !== 1'b1 || rts !== 1'b1) begin n_fail++; $display("FAIL mid_pre count %0d ovf %b rts %b exp 7 1 1", count, overflow, rts); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL mid_count got %0d exp 0", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow got %b exp 0", overflow); end
    n_checks++; if (rts !== 1'b0) begin n_fail++; $display("FAIL mid_rts got %b exp 0", rts); end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    n_checks++; if (overflow !== 1'b1 || overflow !== m_ovf) begin n_fail++; $display("FAIL set_wins got %b exp 1", overflow); end
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (act_q.size() != exp_out_q.size()) begin n_fail++; $display("FAIL mid_nreads got %0d exp %0d", act_q.size(), exp_out_q.size()); end
    while (act_q.size() > 0 && exp_out_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_out_q.pop_front();
      n_checks++; if (a !== e) begin n_fail++; $display("FAIL mid_data got %h exp %h", a, e); end
    end
    act_q.delete(); exp_out_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_rw();
    test_rts();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
